// File: rtl/sw_event_pkg.sv
// sw_event_pkg: controller states, switch-PIO register map and default width
package sw_event_pkg;
  localparam int WIDTH_DEF = 18;
  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;
  typedef enum logic [2:0] {INIT, IDLE, MASK, RD_CAP, CLR, RD_DAT, PUSH} state_t;
endpackage

// File: rtl/sw_event_fifo.sv
// sw_event_fifo: first-word-fall-through event queue; a push into a full queue only lands alongside a pop
module sw_event_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign full = count == CW'(DEPTH);
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign pop = out_valid && out_ready;
  assign in_ready = !full || pop;
  assign push = in_valid && in_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/sw_event_ctrl.sv
// sw_event_ctrl: services switch-PIO interrupts, reading and clearing edge_capture and queueing
// {capture, level} events; also forwards irq_mask updates to the PIO.
module sw_event_ctrl
  import sw_event_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] MASK_INIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic             enable,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_wr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_capture,
  output logic [WIDTH-1:0] evt_level,
  output logic             ovf,
  input  logic             ovf_clr
);
  state_t state;
  logic pending, push, fifo_ready, fifo_full, unused_bits;
  logic [WIDTH-1:0] mask_q, cap;
  logic [2*WIDTH-1:0] head;
  assign push = state == PUSH && cap != '0;
  assign {evt_capture, evt_level} = head;
  assign unused_bits = ^{pio_readdata[31:WIDTH], fifo_full};
  // Bus outputs are registered as each state is entered, so every access lasts exactly one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      pending <= 1'b0;
      mask_q <= '0;
      cap <= '0;
      ovf <= 1'b0;
      pio_address <= PIO_DATA;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_writedata <= '0;
    end else begin
      pio_address <= PIO_DATA;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_writedata <= '0;
      ovf <= (ovf && !ovf_clr) || (push && !fifo_ready);
      if (state == MASK) pending <= 1'b0;
      if (cfg_mask_wr) begin
        mask_q <= cfg_mask;
        pending <= 1'b1;
      end
      case (state)
        INIT: begin
          pio_address <= PIO_MASK;
          pio_chipselect <= 1'b1;
          pio_write_n <= 1'b0;
          pio_writedata <= 32'(MASK_INIT);
          state <= IDLE;
        end
        IDLE:
          if (pending) begin
            pio_address <= PIO_MASK;
            pio_chipselect <= 1'b1;
            pio_write_n <= 1'b0;
            pio_writedata <= 32'(mask_q);
            state <= MASK;
          end else if (pio_irq && enable) begin
            pio_address <= PIO_EDGE;
            pio_chipselect <= 1'b1;
            state <= RD_CAP;
          end
        MASK: state <= IDLE;
        RD_CAP: begin
          pio_address <= PIO_EDGE;
          pio_chipselect <= 1'b1;
          pio_write_n <= 1'b0;
          state <= CLR;
        end
        CLR: begin
          cap <= pio_readdata[WIDTH-1:0];
          pio_address <= PIO_DATA;
          pio_chipselect <= 1'b1;
          state <= RD_DAT;
        end
        RD_DAT: state <= PUSH;
        PUSH: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  // Level is taken straight from the data read returning during PUSH
  sw_event_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .in_valid(push),
    .in_ready(fifo_ready),
    .in_data({cap, pio_readdata[WIDTH-1:0]}),
    .out_valid(evt_valid),
    .out_ready(evt_ready),
    .out_data(head),
    .full(fifo_full)
  );
endmodule

// File: doc/sw_event_ctrl.md
SW_EVENT_CTRL -- requirements
Module: sw_event_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, 18, switch/PIO bit count; DEPTH, 4, event FIFO entries (power of 2, >=2); MASK_INIT, 18'h3FFFF, irq_mask value written after reset.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 pio_address  out  2  switch-PIO word address.
REQ-006 pio_chipselect  out  1  PIO access strobe.
REQ-007 pio_write_n  out  1  active-low write strobe.
REQ-008 pio_writedata  out  32  PIO write data.
REQ-009 pio_readdata  in  32  PIO read data, valid one cycle after address presented.
REQ-010 pio_irq  in  1  PIO interrupt (edge_capture AND irq_mask nonzero).
REQ-011 enable  in  1  permits servicing new interrupts.
REQ-012 cfg_mask  in  WIDTH  new irq_mask value; cfg_mask_wr  in  1  single-cycle request to write it.
REQ-013 evt_valid  out  1 / evt_ready  in  1  event output handshake.
REQ-014 evt_capture  out  WIDTH  captured edge bits; evt_level  out  WIDTH  switch levels at service time.
REQ-015 ovf  out  1  sticky FIFO-overflow flag; ovf_clr  in  1  clears ovf.

Function
REQ-016 PIO map SHALL be: 0 data (read), 2 irq_mask (read/write), 3 edge_capture (read; any write clears all bits).
REQ-017 Idle bus SHALL be address 0, chipselect 0, write_n 1, writedata 0; every access SHALL last exactly one cycle.
REQ-018 FSM states SHALL be INIT, IDLE, MASK, RD_CAP, CLR, RD_DAT, PUSH.
REQ-019 INIT: one-cycle write of MASK_INIT to address 2, then IDLE.
REQ-020 IDLE: pending mask request -> MASK; else pio_irq=1 and enable=1 -> RD_CAP; else stay.
REQ-021 MASK: one-cycle write of latched mask to address 2, clears pending, -> IDLE.
REQ-022 cfg_mask_wr in any state SHALL latch cfg_mask and set pending; later request overwrites earlier (last value wins); mask has priority over irq in IDLE.
REQ-023 RD_CAP: read address 3, -> CLR.
REQ-024 CLR: write 0 to address 3; register pio_readdata[WIDTH-1:0] as cap; -> RD_DAT.
REQ-025 RD_DAT: read address 0, -> PUSH.
REQ-026 PUSH: register pio_readdata[WIDTH-1:0] as level; push {cap, level} if cap nonzero; -> IDLE.
REQ-027 Latency: pio_irq sampled high in IDLE at cycle T SHALL give evt_valid at T+5 when FIFO empty.
REQ-028 Edges arriving in the RD_CAP or CLR cycle are lost (PIO clear has priority); accepted limitation, no recovery.
REQ-029 enable falling mid-sequence SHALL NOT abort it; only new services are blocked.
REQ-030 FIFO: first-word-fall-through, evt_* driven from head; pop when evt_valid and evt_ready.
REQ-031 Push when full SHALL succeed only if pop occurs same cycle; otherwise event dropped and ovf set.
REQ-032 ovf_clr and overflow in same cycle: ovf SHALL end set.
REQ-033 Occupancy counter SHALL wrap-free range 0..DEPTH; pointers wrap modulo DEPTH.

Reset
REQ-034 Reset SHALL force: state INIT, pending 0, FIFO empty, evt_valid 0, evt_capture 0, evt_level 0, ovf 0, bus outputs at idle values.
REQ-035 Reset asserted mid-sequence SHALL abandon it; INIT re-executes on first clock after release.

Structure
REQ-036 Shared package sw_event_pkg SHALL hold the state enum, PIO address constants (DATA=0, MASK=2, EDGE=3) and default WIDTH.
REQ-037 FIFO SHALL be a separate sub-module sw_event_fifo (WIDTH*2 data, DEPTH, valid/ready both sides, full flag).

Verification
REQ-038 Reset release -> cycle 1 write addr 2 data 0x3FFFF, then idle bus.
REQ-039 Switch bit 3 falls (PIO model) with evt_ready=1 -> RD_CAP/CLR/RD_DAT sequence, event capture 0x00008, level reflects switches, at T+5.
REQ-040 cfg_mask_wr 0x00F00 during RD_DAT -> sequence completes, then one write addr 2 data 0x00F00 before next service.
REQ-041 evt_ready=0, five interrupt services (DEPTH=4) -> four events held, ovf=1; ovf_clr -> ovf=0.
REQ-042 Spurious irq with capture read 0 -> full sequence, no event pushed.
REQ-043 Reset asserted in CLR -> outputs idle at once, FIFO empty, INIT write after release.
